isdu_ctrl: RTL and testbench

//  Instruction sequencing/decode FSM for the 16-bit LC-3-subset CPU. Drives the register-file

---
 rtl/lc3_pkg.sv | 46 ++++
 rtl/isdu_wait_ctr.sv | 26 ++
 rtl/isdu_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_isdu_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 sequencing controller: state encoding,
// opcode values and datapath mux/ALU select encodings.
package lc3_pkg;

  typedef enum logic [4:0] {
    S_HALTED,
    S_F1, S_F2, S_F3, S_DEC,
    S_ADD, S_AND, S_NOT,
    S_BR0, S_BR1,
    S_JMP,
    S_J0, S_J1,
    S_L0, S_L1, S_L2,
    S_S0, S_S1, S_S2,
    S_P0, S_P1
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_INC  = 2'b00;
  localparam logic [1:0] PCMUX_BUS  = 2'b01;
  localparam logic [1:0] PCMUX_ADDR = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_SEXT6 = 2'b01;
  localparam logic [1:0] ADDR2_SEXT9 = 2'b10;
  localparam logic [1:0] ADDR2_SEXT11 = 2'b11;

  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_NOT  = 2'b10;
  localparam logic [1:0] ALUK_PASS = 2'b11;

  // States that hold an SRAM strobe for a counted number of cycles.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_F2) || (s == S_L1) || (s == S_S2);
  endfunction

endpackage

// File: rtl/isdu_wait_ctr.sv
// Memory-access wait counter: counts up while enabled and flags done on the
// last cycle of a MEM_WAIT-long access.
module isdu_wait_ctr #(
  parameter int MEM_WAIT = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);

  localparam int W = $clog2(MEM_WAIT + 1);
  localparam logic [W-1:0] LAST = W'(MEM_WAIT - 1);

  logic [W-1:0] r_count;

  // Saturates at LAST so a stalled done never wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) r_count <= '0;
    else if (i_en && !o_done) r_count <= r_count + 1'b1;
  end

  assign o_done = i_en && (r_count == LAST);

endmodule

// File: rtl/isdu_ctrl.sv
// Instruction sequencing/decode FSM for the LC-3 subset: fetch, decode,
// execute, back to fetch; all control lines are decoded from the state.
//
// state  | meaning
// HALTED | idle until Run
// F1     | MAR<-PC, PC<-PC+1
// F2     | SRAM read into MDR, MEM_WAIT cycles
// F3     | IR<-MDR
// DEC    | load BEN, branch on opcode
// ADD/AND/NOT | ALU result to DR, set CC
// BR0/BR1| test BEN / PC<-PC+sext9
// JMP    | PC<-BaseR
// J0/J1  | R7<-PC / PC<-target
// L0..L2 | LDR address, read, writeback
// S0..S2 | STR address, MDR<-SR, write
// P0/P1  | wait for Continue high, then low
module isdu_ctrl
  import lc3_pkg::*;
#(
  parameter int MEM_WAIT = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  state_t r_state;
  state_t w_state_next;
  logic   w_in_mem;
  logic   w_wait_done;

  assign w_in_mem = is_mem_state(r_state);

  // Memory states are never adjacent, so clearing whenever we are outside
  // one guarantees a zero count on every entry.
  isdu_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait_ctr (
    .i_clk  (Clk),
    .i_rst  (Reset),
    .i_clr  (!w_in_mem),
    .i_en   (w_in_mem),
    .o_done (w_wait_done)
  );

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_HALTED;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_HALTED: if (Run) w_state_next = S_F1;
      S_F1:     w_state_next = S_F2;
      S_F2:     if (w_wait_done) w_state_next = S_F3;
      S_F3:     w_state_next = S_DEC;
      S_DEC: begin
        case (Opcode)
          OP_ADD:   w_state_next = S_ADD;
          OP_AND:   w_state_next = S_AND;
          OP_NOT:   w_state_next = S_NOT;
          OP_BR:    w_state_next = S_BR0;
          OP_JMP:   w_state_next = S_JMP;
          OP_JSR:   w_state_next = S_J0;
          OP_LDR:   w_state_next = S_L0;
          OP_STR:   w_state_next = S_S0;
          OP_PAUSE: w_state_next = S_P0;
          default:  w_state_next = S_F1;
        endcase
      end
      S_ADD, S_AND, S_NOT: w_state_next = S_F1;
      S_BR0:    w_state_next = BEN ? S_BR1 : S_F1;
      S_BR1:    w_state_next = S_F1;
      S_JMP:    w_state_next = S_F1;
      S_J0:     w_state_next = S_J1;
      S_J1:     w_state_next = S_F1;
      S_L0:     w_state_next = S_L1;
      S_L1:     if (w_wait_done) w_state_next = S_L2;
      S_L2:     w_state_next = S_F1;
      S_S0:     w_state_next = S_S1;
      S_S1:     w_state_next = S_S2;
      S_S2:     if (w_wait_done) w_state_next = S_F1;
      S_P0:     if (Continue) w_state_next = S_P1;
      S_P1:     if (!Continue) w_state_next = S_F1;
      default:  w_state_next = S_HALTED;
    endcase
  end

  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = PCMUX_INC;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = ADDR2_ZERO;
    ALUK       = ALUK_ADD;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;
    case (r_state)
      S_F1: begin
        LD_MAR = 1'b1;
        GatePC = 1'b1;
        LD_PC  = 1'b1;
        PCMUX  = PCMUX_INC;
      end
      S_F2, S_L1: begin
        Mem_OE = 1'b1;
        LD_MDR = 1'b1;
      end
      S_F3: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      S_DEC: LD_BEN = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        SR2MUX  = ~IR_5;
        ALUK    = (r_state == S_ADD) ? ALUK_ADD :
                  (r_state == S_AND) ? ALUK_AND : ALUK_NOT;
      end
      S_BR1: begin
        LD_PC    = 1'b1;
        PCMUX    = PCMUX_ADDR;
        ADDR2MUX = ADDR2_SEXT9;
      end
      S_JMP: begin
        LD_PC    = 1'b1;
        PCMUX    = PCMUX_ADDR;
        ADDR1MUX = 1'b1;
      end
      S_J0: begin
        GatePC = 1'b1;
        LD_REG = 1'b1;
        DRMUX  = 1'b1;
      end
      // IR is stable for the whole instruction, so IR_11 selects the target.
      S_J1: begin
        LD_PC    = 1'b1;
        PCMUX    = PCMUX_ADDR;
        ADDR1MUX = ~IR_11;
        ADDR2MUX = IR_11 ? ADDR2_SEXT11 : ADDR2_ZERO;
      end
      S_L0, S_S0: begin
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = ADDR2_SEXT6;
      end
      S_L2: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S_S1: begin
        SR1MUX  = 1'b1;
        ALUK    = ALUK_PASS;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
      end
      S_S2: Mem_WE = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_isdu_ctrl.sv
// Directed and random bench for isdu_ctrl: each instruction is expanded into
// its expected per-cycle control word from the instruction-level rules.
module tb_isdu_ctrl;

  localparam int W = 3;

  typedef logic [22:0] ov_t;
  localparam ov_t LD_MAR  = ov_t'(1) << 22;
  localparam ov_t LD_MDR  = ov_t'(1) << 21;
  localparam ov_t LD_IR   = ov_t'(1) << 20;
  localparam ov_t LD_BEN  = ov_t'(1) << 19;
  localparam ov_t LD_CC   = ov_t'(1) << 18;
  localparam ov_t LD_REG  = ov_t'(1) << 17;
  localparam ov_t LD_PC   = ov_t'(1) << 16;
  localparam ov_t G_PC    = ov_t'(1) << 15;
  localparam ov_t G_MDR   = ov_t'(1) << 14;
  localparam ov_t G_ALU   = ov_t'(1) << 13;
  localparam ov_t G_MARM  = ov_t'(1) << 12;
  localparam ov_t PC_ADDR = ov_t'(2) << 10;
  localparam ov_t DR_R7   = ov_t'(1) << 9;
  localparam ov_t SR1_HI  = ov_t'(1) << 8;
  localparam ov_t SR2_REG = ov_t'(1) << 7;
  localparam ov_t A1_SR1  = ov_t'(1) << 6;
  localparam ov_t A2_S6   = ov_t'(1) << 4;
  localparam ov_t A2_S9   = ov_t'(2) << 4;
  localparam ov_t A2_S11  = ov_t'(3) << 4;
  localparam ov_t K_AND   = ov_t'(1) << 2;
  localparam ov_t K_NOT   = ov_t'(2) << 2;
  localparam ov_t K_PASS  = ov_t'(3) << 2;
  localparam ov_t M_OE    = ov_t'(1) << 1;
  localparam ov_t M_WE    = ov_t'(1);

  localparam ov_t E_F1 = LD_MAR | G_PC | LD_PC;
  localparam ov_t E_RD = M_OE | LD_MDR;
  localparam ov_t E_F3 = G_MDR | LD_IR;
  localparam ov_t E_ADR6 = G_MARM | LD_MAR | A1_SR1 | A2_S6;

  logic Clk = 1'b0, Reset = 1'b1, Run = 1'b0, Continue = 1'b0;
  logic [3:0] Opcode = 4'h0;
  logic IR_5 = 1'b0, IR_11 = 1'b0, BEN = 1'b0;
  logic LD_MAR_o, LD_MDR_o, LD_IR_o, LD_BEN_o, LD_CC_o, LD_REG_o, LD_PC_o;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE;
  ov_t w_obs;

  int n_cmp = 0;
  int n_err = 0;

  ov_t    q_exp[$];
  logic   q_cont[$];
  string  q_tag[$];

  always #5 Clk = ~Clk;

  isdu_ctrl #(.MEM_WAIT(W)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR_o), .LD_MDR(LD_MDR_o), .LD_IR(LD_IR_o), .LD_BEN(LD_BEN_o),
    .LD_CC(LD_CC_o), .LD_REG(LD_REG_o), .LD_PC(LD_PC_o),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  assign w_obs = {LD_MAR_o, LD_MDR_o, LD_IR_o, LD_BEN_o, LD_CC_o, LD_REG_o, LD_PC_o,
                  GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
                  ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};

  task automatic tick_check(input ov_t e, input string tag);
    @(posedge Clk);
    @(negedge Clk);
    n_cmp++;
    assert (w_obs === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, w_obs, e);
    end
  endtask

  task automatic push(input ov_t e, input string tag, input logic c);
    q_exp.push_back(e);
    q_tag.push_back(tag);
    q_cont.push_back(c);
  endtask

  // Expected control words for one instruction, from the cycle after F1 up to
  // and including the next F1.
  task automatic build(input logic [3:0] op, input logic ir5, input logic ir11,
                       input logic ben, input int k, input int m);
    ov_t alu;
    for (int i = 0; i < W; i++) push(E_RD, "F2", 1'b0);
    push(E_F3, "F3", 1'b0);
    push(LD_BEN, "DEC", 1'b0);
    alu = G_ALU | LD_REG | LD_CC | (ir5 ? ov_t'(0) : SR2_REG);
    case (op)
      4'b0001: push(alu, "ADD", 1'b0);
      4'b0101: push(alu | K_AND, "AND", 1'b0);
      4'b1001: push(alu | K_NOT, "NOT", 1'b0);
      4'b0000: begin
        push('0, "BR0", 1'b0);
        if (ben) push(LD_PC | PC_ADDR | A2_S9, "BR1", 1'b0);
      end
      4'b1100: push(LD_PC | PC_ADDR | A1_SR1, "JMP", 1'b0);
      4'b0100: begin
        push(G_PC | LD_REG | DR_R7, "J0", 1'b0);
        push(LD_PC | PC_ADDR | (ir11 ? A2_S11 : A1_SR1), "J1", 1'b0);
      end
      4'b0110: begin
        push(E_ADR6, "L0", 1'b0);
        for (int i = 0; i < W; i++) push(E_RD, "L1", 1'b0);
        push(G_MDR | LD_REG | LD_CC, "L2", 1'b0);
      end
      4'b0111: begin
        push(E_ADR6, "S0", 1'b0);
        push(SR1_HI | K_PASS | G_ALU | LD_MDR, "S1", 1'b0);
        for (int i = 0; i < W; i++) push(M_WE, "S2", 1'b0);
      end
      4'b1101: begin
        push('0, "P0", 1'b0);
        for (int i = 0; i < k; i++) push('0, "P0wait", 1'b0);
        push('0, "P1", 1'b1);
        for (int i = 0; i < m; i++) push('0, "P1wait", 1'b1);
        push(E_F1, "F1", 1'b0);
        return;
      end
      default: ;
    endcase
    push(E_F1, "F1", 1'b0);
  endtask

  // Continue value for step j is driven before the edge leading into it;
  // Run is randomised to show it is ignored outside HALTED.
  task automatic play(input logic [3:0] op, input logic ir5, input logic ir11,
                      input logic ben);
    Opcode = op; IR_5 = ir5; IR_11 = ir11; BEN = ben;
    while (q_exp.size() > 0) begin
      Continue = q_cont.pop_front();
      Run = 1'($urandom);
      tick_check(q_exp.pop_front(), q_tag.pop_front());
    end
    Run = 1'b0;
    Continue = 1'b0;
  endtask

  task automatic instr(input logic [3:0] op, input logic ir5, input logic ir11,
                       input logic ben);
    build(op, ir5, ir11, ben, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    play(op, ir5, ir11, ben);
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0;
    tick_check('0, "reset1");
    tick_check('0, "reset2");
    Reset = 1'b0;
    tick_check('0, "halted_idle");
    Run = 1'b1;
    tick_check(E_F1, "run_to_F1");
    Run = 1'b0;

    instr(4'b0001, 1'b1, 1'b0, 1'b0);
    instr(4'b0001, 1'b0, 1'b0, 1'b0);
    instr(4'b0000, 1'b0, 1'b0, 1'b0);
    instr(4'b0000, 1'b0, 1'b0, 1'b1);
    instr(4'b0111, 1'b0, 1'b0, 1'b0);
    instr(4'b0100, 1'b0, 1'b1, 1'b0);
    instr(4'b0100, 1'b0, 1'b0, 1'b0);
    instr(4'b0110, 1'b1, 1'b0, 1'b0);
    instr(4'b1101, 1'b0, 1'b0, 1'b0);
    instr(4'b1111, 1'b0, 1'b0, 1'b0);

    tick_check(E_RD, "F2_wait1");
    tick_check(E_RD, "F2_wait2");
    Reset = 1'b1;
    tick_check('0, "reset_mid_wait");
    Reset = 1'b0;
    tick_check('0, "halted_after_reset");
    Run = 1'b1;
    tick_check(E_F1, "restart_F1");
    Run = 1'b0;
    instr(4'b0101, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 150; n++)
      instr(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
